// File: rtl/dm_resp.sv
// -----------------------------------------------------------------------------
// dm_resp -- data-memory responder for the single-cycle core's data port.
//
// Stores go into a one-entry posted write buffer and are written into RAM on
// the next edge. Loads (rdata) and the debug port (dbg_data) are combinational.
// Both forward any pending buffer lanes, so a load in the next instruction
// always sees the previous store.
//
// Parameters:
//   AW     word-address width; RAM depth is 2**AW 32-bit words
//   CNT_W  width of the accepted-store counter
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   addr       byte address; [AW+1:2] selects the word, upper bits alias
//   wdata      store data
//   mem_write  store request
//   dm_sh      halfword store qualifier
//   dm_sb      byte store qualifier (wins over dm_sh)
//   rdata      word at addr with buffer forwarding
//   dbg_addr   debug word index
//   dbg_data   word at dbg_addr with buffer forwarding
//   align_err  sticky misaligned-store flag
//   store_cnt  number of accepted stores (wraps)
// -----------------------------------------------------------------------------
module dm_resp #(
    parameter int AW    = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              mem_write,
    input  logic              dm_sh,
    input  logic              dm_sb,
    output logic [31:0]       rdata,
    input  logic [AW-1:0]     dbg_addr,
    output logic [31:0]       dbg_data,
    output logic              align_err,
    output logic [CNT_W-1:0]  store_cnt
);

    localparam int DEPTH = 1 << AW;

    // Upper address bits alias onto the same RAM word by design.
    logic addr_unused;
    assign addr_unused = ^addr[31:AW+2];

    logic [AW-1:0] rd_idx;
    assign rd_idx = addr[AW+1:2];

    // Write buffer
    logic              buf_valid_reg;
    logic [AW-1:0]     buf_idx_reg;
    logic [31:0]       buf_data_reg;
    logic [3:0]        buf_mask_reg;
    logic              align_err_reg;
    logic [CNT_W-1:0]  store_cnt_reg;

    // Cleared by reset and set on the first edge after release. A store that
    // lands on the same edge as reset release is therefore never captured,
    // whatever order the simulator evaluates the two events in.
    logic              armed_reg;

    // Store decode. Sub-word data is replicated on every lane; the mask
    // picks the lane(s) that actually get written.
    logic [3:0]        store_mask_next;
    logic [31:0]       store_data_next;
    logic              misaligned_next;
    logic              store_ok_next;
    logic              store_bad_next;

    always_comb begin
        store_mask_next = 4'b1111;
        store_data_next = wdata;
        misaligned_next = 1'b0;
        if (dm_sb) begin
            store_mask_next = 4'b0001 << addr[1:0];
            store_data_next = {4{wdata[7:0]}};
        end else if (dm_sh) begin
            store_mask_next = addr[1] ? 4'b1100 : 4'b0011;
            store_data_next = {2{wdata[15:0]}};
            misaligned_next = addr[0];
        end else begin
            misaligned_next = |addr[1:0];
        end
    end

    assign store_ok_next  = mem_write && armed_reg && !misaligned_next;
    assign store_bad_next = mem_write && armed_reg &&  misaligned_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_reg     <= 1'b0;
            buf_valid_reg <= 1'b0;
            buf_idx_reg   <= '0;
            buf_data_reg  <= '0;
            buf_mask_reg  <= '0;
            align_err_reg <= 1'b0;
            store_cnt_reg <= '0;
        end else begin
            armed_reg <= 1'b1;
            if (store_ok_next) begin
                buf_valid_reg <= 1'b1;
                buf_idx_reg   <= rd_idx;
                buf_data_reg  <= store_data_next;
                buf_mask_reg  <= store_mask_next;
                store_cnt_reg <= store_cnt_reg + CNT_W'(1);
            end else begin
                buf_valid_reg <= 1'b0;
            end
            if (store_bad_next) begin
                align_err_reg <= 1'b1;
            end
        end
    end

    // RAM is split into four byte-lane arrays so each lane has its own write
    // enable. Reset clears buf_valid_reg asynchronously, so a pending store
    // caught by reset never reaches RAM. RAM contents survive reset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_ram [0:DEPTH-1];
            logic       fwd_rd;
            logic       fwd_dbg;

            always_ff @(posedge clk) begin
                if (buf_valid_reg && buf_mask_reg[gi]) begin
                    lane_ram[buf_idx_reg] <= buf_data_reg[8*gi +: 8];
                end
            end

            assign fwd_rd  = buf_valid_reg && buf_mask_reg[gi] && (buf_idx_reg == rd_idx);
            assign fwd_dbg = buf_valid_reg && buf_mask_reg[gi] && (buf_idx_reg == dbg_addr);

            assign rdata[8*gi +: 8]    = fwd_rd  ? buf_data_reg[8*gi +: 8] : lane_ram[rd_idx];
            assign dbg_data[8*gi +: 8] = fwd_dbg ? buf_data_reg[8*gi +: 8] : lane_ram[dbg_addr];
        end
    endgenerate

    assign align_err = align_err_reg;
    assign store_cnt = store_cnt_reg;

endmodule
